stream_unpacker: RTL and testbench
==================================

// Module: stream_unpacker
// PURPOSE
//  Parametrised width-down-converter for sop/eop packet streams: accepts wide words on a
//  valid/ready input, emits RATIO narrow beats per word on a valid/ready output, MSB lane first.
//  Sits between the wide interfaceInput-style packet source and the narrow packer output path.
//  Supports partial final words (in_empty) and flags sop/eop framing violations.
// PARAMETERS
//  OUT_WIDTH  8   width of one output beat (bits)
//  RATIO      4   output beats per input word; must be a power of two, >= 2
//  (localparam IN_WIDTH = OUT_WIDTH*RATIO; EMPTY_W = $clog2(RATIO))
// PORTS
//  clk        in   1         single clock, all logic on posedge
//  rstn       in   1         reset, synchronous, active-low
//  in_valid   in   1         input word valid
//  in_ready   out  1         block can accept a word this cycle
//  in_data    in   IN_WIDTH  input word; lane 0 = in_data[IN_WIDTH-1 -: OUT_WIDTH]
//  in_sop     in   1         word is first of packet
//  in_eop     in   1         word is last of packet
//  in_empty   in   EMPTY_W   unused trailing lanes in eop word; ignored when in_eop=0
//  out_valid  out  1         output beat valid
//  out_ready  in   1         sink accepts beat
//  out_data   out  OUT_WIDTH output beat
//  out_sop    out  1         first beat of packet
//  out_eop    out  1         last beat of packet
//  err        out  1         one-cycle pulse on framing violation
// BEHAVIOUR
//  - Reset (rstn=0 at posedge): out_valid=0, out_data=0, out_sop=0, out_eop=0, err=0, FSM->IDLE,
//    in_pkt=0, lane counter=0. Held word discarded; applies mid-packet too. in_ready=0 during reset.
//  - Transfer on a port = valid && ready at posedge. Outputs registered; held stable while
//    out_valid && !out_ready.
//  - FSM: IDLE (no word held) / SHIFT (word held, emitting lanes).
//    IDLE: in_ready=1; on input transfer -> SHIFT, load word, lane=0.
//    SHIFT: emit lane `lane`; on output transfer lane++; at last lane transfer either
//    load next word if input transfer same cycle (stay SHIFT) or -> IDLE.
//  - in_ready = rstn && (IDLE || (SHIFT && out_valid && out_ready && lane==last)); combinational
//    on out_ready. Gives zero-bubble throughput: one beat per cycle while in_valid and out_ready held.
//  - Latency: word accepted at edge N -> lane 0 on out_valid after edge N (cycle N+1).
//  - Beats per word: RATIO if !in_eop, else RATIO - in_empty (1..RATIO). last = beats-1.
//  - out_sop=1 only on lane 0 of a word accepted with in_sop. out_eop=1 only on last lane of a
//    word accepted with in_eop. sop&&eop single-word packet: both flags per above.
//  - in_pkt: set on accepting a sop word without eop, cleared on accepting an eop word.
//  - err pulses (one cycle, cycle after accept) when: in_sop accepted while in_pkt=1, or
//    non-sop word accepted while in_pkt=0. Word still forwarded unchanged; in_pkt updated as normal.
//  - Lane counter width EMPTY_W, never wraps beyond last; no arithmetic overflow possible.
// TESTING (OUT_WIDTH=8, RATIO=4 unless stated)
//  1 Reset: hold rstn=0 2 cycles with in_valid=1 -> out_valid=0, in_ready=0, err=0; first word
//    accepted only after rstn=1.
//  2 Packet 0xAABBCCDD(sop) then 0x11223344(eop,empty=1), out_ready=1 -> AA(sop),BB,CC,DD,11,22,
//    33(eop) on 7 consecutive cycles, no bubble, in_ready high on DD and IDLE cycles only.
//  3 Backpressure: same packet, out_ready toggled 1,0,0,1... -> out_data/flags stable while
//    stalled, same 7-beat sequence, no loss or duplication.
//  4 Single-word packet 0xDEADBEEF sop+eop empty=3 -> one beat DE with out_sop=out_eop=1.
//  5 Framing: sop word, then second sop word -> err pulse 1 cycle; both words emitted intact;
//    then non-sop word with in_pkt=0 -> err pulse.
//  6 rstn=0 after 2 of 4 lanes emitted -> out_valid=0 next cycle, remaining lanes never emitted,
//    next packet after reset starts clean with out_sop=1.

Source files
------------

// File: rtl/stream_unpacker.sv
// Width-down-converter for sop/eop packet streams: one wide word in, RATIO narrow beats out
// (MSB lane first), with partial final words and sop/eop framing-violation reporting.
module stream_unpacker #(
  parameter  int OUT_WIDTH = 8,
  parameter  int RATIO     = 4,
  localparam int IN_WIDTH  = OUT_WIDTH * RATIO,
  localparam int EMPTY_W   = $clog2(RATIO)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic                 in_sop,
  input  logic                 in_eop,
  input  logic [EMPTY_W-1:0]   in_empty,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_sop,
  output logic                 out_eop,
  output logic                 err
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [IN_WIDTH-1:0]  word_q;
  logic [EMPTY_W-1:0]   lane_q;
  logic [EMPTY_W-1:0]   last_q;
  logic                 eop_q;
  logic                 in_pkt_q;
  logic                 out_valid_q;
  logic [OUT_WIDTH-1:0] out_data_q;
  logic                 out_sop_q;
  logic                 out_eop_q;
  logic                 err_q;

  logic                 out_fire;
  logic                 in_fire;
  logic                 at_last;
  logic                 violation;
  logic [EMPTY_W-1:0]   lane_nx;
  logic [EMPTY_W-1:0]   in_last;

  function automatic logic [OUT_WIDTH-1:0] lane_of(input logic [IN_WIDTH-1:0] w,
                                                   input logic [EMPTY_W-1:0]  idx);
    logic [OUT_WIDTH-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < RATIO; i++) begin
      if (idx == EMPTY_W'(i)) r = w[IN_WIDTH-1-i*OUT_WIDTH -: OUT_WIDTH];
    end
    return r;
  endfunction

  assign out_fire  = out_valid_q && out_ready;
  assign at_last   = (lane_q == last_q);
  assign in_fire   = in_valid && in_ready;
  assign lane_nx   = lane_q + EMPTY_W'(1);
  // RATIO-1 is all ones in EMPTY_W bits, so the last lane index is simply ~in_empty.
  assign in_last   = in_eop ? ~in_empty : '1;
  assign violation = in_sop ? in_pkt_q : !in_pkt_q;

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_fire) state_d = SHIFT;
      SHIFT:   if (out_fire && at_last) state_d = in_fire ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: in_ready is combinational on out_ready for zero-bubble reloads
  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      IDLE:    in_ready = rstn;
      SHIFT:   in_ready = rstn && out_fire && at_last;
      default: in_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      word_q      <= '0;
      lane_q      <= '0;
      last_q      <= '0;
      eop_q       <= 1'b0;
      in_pkt_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      err_q <= in_fire && violation;
      if (in_fire) begin
        word_q      <= in_data;
        lane_q      <= '0;
        last_q      <= in_last;
        eop_q       <= in_eop;
        out_valid_q <= 1'b1;
        out_data_q  <= in_data[IN_WIDTH-1 -: OUT_WIDTH];
        out_sop_q   <= in_sop;
        out_eop_q   <= in_eop && (in_last == '0);
        if (in_eop)      in_pkt_q <= 1'b0;
        else if (in_sop) in_pkt_q <= 1'b1;
      end else if (out_fire) begin
        out_sop_q <= 1'b0;
        if (at_last) begin
          out_valid_q <= 1'b0;
          out_eop_q   <= 1'b0;
        end else begin
          lane_q     <= lane_nx;
          out_data_q <= lane_of(word_q, lane_nx);
          out_eop_q  <= eop_q && (lane_nx == last_q);
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sop   = out_sop_q;
  assign out_eop   = out_eop_q;
  assign err       = err_q;

endmodule

// File: tb/tb_stream_unpacker.sv
// Self-checking bench for stream_unpacker (OUT_WIDTH=8, RATIO=4): word table driven through a
// beat scoreboard, with and without output backpressure, plus reset-related sequences.
module tb_stream_unpacker;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_sop;
  logic        in_eop;
  logic [1:0]  in_empty;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_sop;
  logic        out_eop;
  logic        err;

  stream_unpacker #(.OUT_WIDTH(8), .RATIO(4)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sop    (in_sop),
    .in_eop    (in_eop),
    .in_empty  (in_empty),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sop   (out_sop),
    .out_eop   (out_eop),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    bit         sop;
    bit         eop;
    bit         last;
  } beat_t;

  typedef struct {
    logic [31:0] data;
    bit          sop;
    bit          eop;
    logic [1:0]  empty;
    bit          exp_err;
  } vec_t;

  beat_t      q[$];
  vec_t       tbl[8];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         bp_mode = 0;
  bit         stall_prev = 0;
  logic [7:0] sv_data;
  logic       sv_sop, sv_eop;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_word(input logic [31:0] d, input bit s, input bit e, input logic [1:0] emp);
    int    beats;
    beat_t b;
    beats = e ? 4 - int'(emp) : 4;
    for (int k = 0; k < beats; k++) begin
      b.d    = d[31-8*k -: 8];
      b.sop  = s && (k == 0);
      b.eop  = e && (k == beats - 1);
      b.last = (k == beats - 1);
      q.push_back(b);
    end
  endtask

  // One clock: drive after negedge, sample at negedge+1, check registered err after posedge.
  task automatic cycle(input bit iv, input logic [31:0] d, input bit s, input bit e,
                       input logic [1:0] emp, input bit exp_err, output bit acc);
    bit exp_rdy;
    bit held;
    @(negedge clk);
    out_ready = (bp_mode == 0) ? 1'b1 : (cyc % 3 == 0);
    cyc++;
    in_valid = iv; in_data = d; in_sop = s; in_eop = e; in_empty = emp;
    #1;
    held    = (q.size() != 0);
    exp_rdy = rstn && (!held || (out_ready && q[0].last));
    chk("in_ready", in_ready, exp_rdy);
    if (rstn) begin
      chk("out_valid", out_valid, held);
      if (stall_prev) begin
        chk("stall_data", out_data, sv_data);
        chk("stall_sop", out_sop, sv_sop);
        chk("stall_eop", out_eop, sv_eop);
      end
      if (held && out_ready) begin
        chk("out_data", out_data, q[0].d);
        chk("out_sop", out_sop, q[0].sop);
        chk("out_eop", out_eop, q[0].eop);
        void'(q.pop_front());
      end
    end
    acc = iv && exp_rdy;
    if (acc) push_word(d, s, e, emp);
    stall_prev = rstn && held && !out_ready;
    sv_data = out_data; sv_sop = out_sop; sv_eop = out_eop;
    @(posedge clk);
    #1;
    if (!rstn) begin
      q.delete();
      stall_prev = 0;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_err", err, 1'b0);
    end else begin
      chk("err", err, acc && exp_err);
    end
  endtask

  task automatic send(input vec_t v);
    bit acc = 0;
    int n = 0;
    while (!acc && n < 50) begin
      cycle(1'b1, v.data, v.sop, v.eop, v.empty, v.exp_err, acc);
      n++;
    end
    if (!acc) begin
      checks++; errors++;
      $display("FAIL send_timeout: word %0h not accepted", v.data);
    end
  endtask

  task automatic idle();
    bit acc;
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0, acc);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      idle();
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d beats pending expected 0", q.size());
    end
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{32'hAABBCCDD, 1, 0, 2'd0, 0};
    tbl[1] = '{32'h11223344, 0, 1, 2'd1, 0};
    tbl[2] = '{32'hDEADBEEF, 1, 1, 2'd3, 0};
    tbl[3] = '{32'hCAFEF00D, 1, 0, 2'd0, 0};
    tbl[4] = '{32'h12345678, 1, 0, 2'd0, 1};
    tbl[5] = '{32'h9ABCDEF0, 0, 1, 2'd0, 0};
    tbl[6] = '{32'h55667788, 0, 0, 2'd0, 1};
    tbl[7] = '{32'hA1B2C3D4, 0, 1, 2'd2, 1};

    // Reset held with a word offered: nothing may be accepted or emitted.
    rstn = 1'b0;
    in_valid = 1'b0; in_data = '0; in_sop = 0; in_eop = 0; in_empty = '0; out_ready = 1'b1;
    begin
      bit acc;
      cycle(1'b1, tbl[0].data, 1'b1, 1'b0, 2'd0, 1'b0, acc);
      cycle(1'b1, tbl[0].data, 1'b1, 1'b0, 2'd0, 1'b0, acc);
    end
    rstn = 1'b1;

    // Table pass without and then with backpressure (out_ready 1,0,0,...).
    for (int m = 0; m < 2; m++) begin
      bp_mode = m;
      cyc = 0;
      for (int i = 0; i < 8; i++) send(tbl[i]);
      drain();
    end

    // Reset after two lanes have gone out: rest of the word must vanish.
    bp_mode = 0;
    send('{32'h01020304, 1, 0, 2'd0, 0});
    idle();
    idle();
    rstn = 1'b0;
    idle();
    rstn = 1'b1;
    idle();
    send(tbl[2]);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
